// File: rtl/inst_fetch_queue_pkg.sv
// Package: inst_fetch_queue_pkg
// Shared types and constants for the instruction fetch queue.
//   addr_t       64-bit program counter
//   inst_t       32-bit instruction word
//   ifq_entry_t  one queue entry {pc, inst}
//   sat_add64    saturating 64-bit add used by the optional statistics counters
//                (statistics are built only when IFQ_STAT_EN is defined)
package inst_fetch_queue_pkg;

    localparam int OPCODE_W    = 7;
    localparam int IMM_FIELD_W = 25;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } ifq_entry_t;

    // Sticks at all-ones instead of wrapping.
    function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[64] ? '1 : sum[63:0];
    endfunction

endpackage

// File: rtl/inst_fetch_queue_storage.sv
// Module: inst_fetch_queue_storage
// DEPTH x ifq_entry_t register array, one write port, one asynchronous read port.
//   clk      core clock
//   wr_en    write strobe
//   wr_addr  entry written on the rising edge when wr_en is high
//   wr_data  entry contents to write
//   rd_addr  entry to read
//   rd_data  contents of rd_addr (combinational)
// Contents are not reset; the top masks reads while the queue is empty.
module inst_fetch_queue_storage
    import inst_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  ifq_entry_t       wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output ifq_entry_t       rd_data
);

    ifq_entry_t mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == PTR_W'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Module: inst_fetch_queue
// Instruction buffer between fetch and decode with valid/ready on both sides
// and a flush for redirects/traps. Head instruction is also presented split
// into opcode and inst[31:7] for the immediate generator.
//   clk, rst                      clock, synchronous active-high reset
//   flush                         discard all entries and the current input
//   in_valid/in_ready/in_pc/in_inst          fetch side
//   out_valid/out_ready/out_pc/out_inst      decode side
//   out_opcode, out_imm_field     head inst[6:0], head inst[31:7]
//   out_count                     current occupancy (0..DEPTH)
// Optional (macro IFQ_STAT_EN): stat_full_cycles, stat_flushed, stat_accepted,
// saturating 64-bit counters cleared by rst.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  addr_t                  in_pc,
    input  inst_t                  in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output addr_t                  out_pc,
    output inst_t                  out_inst,
    output logic [OPCODE_W-1:0]    out_opcode,
    output logic [IMM_FIELD_W-1:0] out_imm_field,
    output logic [PTR_W:0]         out_count
`ifdef IFQ_STAT_EN
    ,
    output logic [63:0]            stat_full_cycles,
    output logic [63:0]            stat_flushed,
    output logic [63:0]            stat_accepted
`endif
);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    ifq_entry_t       wr_entry;
    ifq_entry_t       head_entry;

    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);

    // Ready comes only from registered state, so a full queue refuses input
    // even in a cycle where decode pops.
    assign in_ready  = !full && !flush;
    assign out_valid = !empty && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_entry.pc   = in_pc;
    assign wr_entry.inst = in_inst;

    inst_fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_ifq_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_entry)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Stale storage never leaks out: an empty queue presents zeros.
    assign out_pc        = empty ? '0 : head_entry.pc;
    assign out_inst      = empty ? '0 : head_entry.inst;
    assign out_opcode    = out_inst[OPCODE_W-1:0];
    assign out_imm_field = out_inst[31:OPCODE_W];
    assign out_count     = count_reg;

`ifdef IFQ_STAT_EN
    logic [63:0] stat_full_cycles_reg;
    logic [63:0] stat_flushed_reg;
    logic [63:0] stat_accepted_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_full_cycles_reg <= '0;
            stat_flushed_reg     <= '0;
            stat_accepted_reg    <= '0;
        end else begin
            if (full && in_valid) begin
                stat_full_cycles_reg <= sat_add64(stat_full_cycles_reg, 64'd1);
            end
            if (flush) begin
                stat_flushed_reg <= sat_add64(stat_flushed_reg, 64'(count_reg));
            end
            if (push) begin
                stat_accepted_reg <= sat_add64(stat_accepted_reg, 64'd1);
            end
        end
    end

    assign stat_full_cycles = stat_full_cycles_reg;
    assign stat_flushed     = stat_flushed_reg;
    assign stat_accepted    = stat_accepted_reg;
`endif

endmodule
